uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter (tdr/tsr pair behind `pl`/`d_i`) between NUM_REQ byte sources.
- Picks a winner, presents its word on `d_o`, and pulses `pl` for one cycle.
- Then owns the transmitter for a fixed number of `bit_tick` pulses (one full frame) before granting again.
- Sits between the application-side requesters and the tx block; shares `bit_tick` with the baud generator.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART transmitter between NUM_REQ byte sources; grants
//            one word, strobes pl, then holds off for FRAME_TICKS bit ticks.
//            Define UART_TX_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int DATA_SIZE   = 7,
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = DATA_SIZE + 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   data_flat,
    input  logic                           bit_tick,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           pl,
    output logic [DATA_SIZE-1:0]           d_o,
    output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(FRAME_TICKS + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   w_win;
    logic                 w_any_req;
    logic                 w_last_tick;
    logic                 w_pl_nxt;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic                 w_busy_nxt;
    logic                 w_fd_nxt;

    assign w_any_req   = |req;
    assign w_last_tick = (r_state == c_WAIT) && bit_tick &&
                         (r_cnt == c_CNT_W'(FRAME_TICKS - 1));

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) w_win = c_IDX_W'(i);
        end
    end
`else
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] w_idx;
    int                 w_sum;

    // Scan from the farthest slot back to r_ptr so the nearest request wins.
    always_comb begin
        w_win = r_ptr;
        w_idx = '0;
        w_sum = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_idx = c_IDX_W'(w_sum);
            if (req[w_idx]) w_win = w_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_pl_nxt) begin
            r_ptr <= (w_win == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req)   w_state_nxt = c_LOAD;
            c_LOAD:                   w_state_nxt = c_WAIT;
            c_WAIT:  if (w_last_tick) w_state_nxt = c_IDLE;
            default:                  w_state_nxt = c_IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        w_pl_nxt   = (r_state == c_IDLE) && w_any_req;
        w_ack_nxt  = '0;
        if (w_pl_nxt) w_ack_nxt[w_win] = 1'b1;
        w_busy_nxt = (w_state_nxt == c_LOAD) || (w_state_nxt == c_WAIT);
        w_fd_nxt   = w_last_tick;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack        <= '0;
            pl         <= 1'b0;
            d_o        <= '0;
            grant_idx  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            r_cnt      <= '0;
        end else begin
            ack        <= w_ack_nxt;
            pl         <= w_pl_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_fd_nxt;
            if (w_pl_nxt) begin
                d_o       <= data_flat[w_win*DATA_SIZE +: DATA_SIZE];
                grant_idx <= w_win;
            end
            // A tick seen during LOAD is deliberately dropped.
            if (r_state == c_LOAD) begin
                r_cnt <= '0;
            end else if ((r_state == c_WAIT) && bit_tick && !w_last_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed, table-driven bench for uart_tx_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int DS = 7;
    localparam int NR = 4;
    localparam int FT = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DS-1:0]  data_flat;
    logic              bit_tick;
    logic [NR-1:0]     ack;
    logic              pl;
    logic [DS-1:0]     d_o;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              frame_done;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.DATA_SIZE(DS), .NUM_REQ(NR), .FRAME_TICKS(FT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_flat  (data_flat),
        .bit_tick   (bit_tick),
        .ack        (ack),
        .pl         (pl),
        .d_o        (d_o),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       req;
        logic [3:0][6:0]  w;
        logic             tick_load;
        int               exp_rr;
        int               exp_fp;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(input logic [3:0] r, input logic [6:0] a, input logic [6:0] b,
                                input logic [6:0] c, input logic [6:0] d, input logic t,
                                input int rr, input int fp);
        vec_t v;
        v.req       = r;
        v.w         = {d, c, b, a};
        v.tick_load = t;
        v.exp_rr    = rr;
        v.exp_fp    = fp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for pl after a request appeared; the grant must land one cycle later.
    task automatic pick(input int exp_idx, input logic [6:0] exp_d);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!pl && n < 20);
        chk("req_to_pl_latency", n, 1);
        chk("pl", {31'd0, pl}, 1);
        chk("ack", {28'd0, ack}, 32'd1 << exp_idx);
        chk("grant_idx", {30'd0, grant_idx}, exp_idx);
        chk("d_o_at_load", {25'd0, d_o}, {25'd0, exp_d});
        chk("busy_at_load", {31'd0, busy}, 1);
    endtask

    // Called in the LOAD cycle; returns in the frame_done cycle.
    task automatic do_frame(input logic tick_load, input logic scramble, input logic [6:0] exp_d);
        int  nt;
        int  guard;
        bit  ph;
        bit  done;
        bit_tick = tick_load;
        step();
        bit_tick = 1'b0;
        chk("pl_one_cycle", {31'd0, pl}, 0);
        chk("ack_one_cycle", {28'd0, ack}, 0);
        chk("busy_in_wait", {31'd0, busy}, 1);
        if (scramble) data_flat = ~data_flat;
        nt = 0; guard = 0; ph = 1'b1; done = 1'b0;
        while (!done && guard < 100) begin
            bit_tick = ph;
            step();
            if (ph) nt++;
            ph = ~ph;
            bit_tick = 1'b0;
            guard++;
            if (frame_done) done = 1'b1;
            else if (busy !== 1'b1 || pl !== 1'b0) chk("busy_during_frame", {30'd0, busy, pl}, 2);
        end
        chk("frame_seen", {31'd0, done}, 1);
        chk("frame_ticks", nt, FT);
        chk("busy_at_frame_done", {31'd0, busy}, 0);
        chk("d_o_held", {25'd0, d_o}, {25'd0, exp_d});
    endtask

    initial begin
        int exp_held [5];
        int e;
        reset     = 1'b1;
        req       = 4'b1111;
        bit_tick  = 1'b0;
        data_flat = {7'h44, 7'h33, 7'h22, 7'h11};

        tbl[0] = mk(4'b0100, 7'h01, 7'h02, 7'h55, 7'h03, 1'b0, 2, 2);
        tbl[1] = mk(4'b0010, 7'h10, 7'h2A, 7'h30, 7'h40, 1'b0, 1, 1);
        tbl[2] = mk(4'b0011, 7'h7F, 7'h66, 7'h00, 7'h00, 1'b0, 0, 0);
        tbl[3] = mk(4'b1001, 7'h12, 7'h34, 7'h56, 7'h78, 1'b0, 3, 0);
        tbl[4] = mk(4'b1000, 7'h01, 7'h01, 7'h01, 7'h3C, 1'b1, 3, 3);
        tbl[5] = mk(4'b0001, 7'h5A, 7'h00, 7'h00, 7'h00, 1'b1, 0, 0);
        tbl[6] = mk(4'b1111, 7'h01, 7'h6E, 7'h03, 7'h04, 1'b0, 1, 0);
        tbl[7] = mk(4'b0101, 7'h09, 7'h08, 7'h77, 7'h06, 1'b0, 2, 0);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_held = '{0, 0, 0, 0, 0};
`else
        exp_held = '{0, 1, 2, 3, 0};
`endif

        step();
        step();
        chk("reset_pl", {31'd0, pl}, 0);
        chk("reset_ack", {28'd0, ack}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_frame_done", {31'd0, frame_done}, 0);
        chk("reset_d_o", {25'd0, d_o}, 0);
        chk("reset_grant_idx", {30'd0, grant_idx}, 0);

        // All requesters held high from reset.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pick(exp_held[i], data_flat[exp_held[i]*DS +: DS]);
            do_frame(1'b0, 1'b0, data_flat[exp_held[i]*DS +: DS]);
        end

        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            e = tbl[i].exp_fp;
`else
            e = tbl[i].exp_rr;
`endif
            req       = tbl[i].req;
            data_flat = tbl[i].w;
            pick(e, tbl[i].w[e]);
            req[e] = 1'b0;
            do_frame(tbl[i].tick_load, 1'b1, tbl[i].w[e]);
        end

        // Frame_done is a single pulse and nothing fires without a request.
        req = '0;
        step();
        chk("frame_done_one_cycle", {31'd0, frame_done}, 0);
        chk("idle_no_pl", {31'd0, pl}, 0);
        chk("idle_no_busy", {31'd0, busy}, 0);

        // Asynchronous reset in the middle of a frame.
        req       = 4'b0100;
        data_flat = {7'h0F, 7'h55, 7'h1E, 7'h2D};
        pick(2, 7'h55);
        req = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
            step();
        end
        chk("busy_before_reset", {31'd0, busy}, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", {31'd0, busy}, 0);
        chk("async_reset_d_o", {25'd0, d_o}, 0);
        chk("async_reset_grant_idx", {30'd0, grant_idx}, 0);
        chk("async_reset_pl_ack_fd", {26'd0, pl, ack, frame_done}, 0);
        step();
        reset = 1'b0;
        req   = 4'b0010;
        pick(1, 7'h1E);
        req[1] = 1'b0;
        do_frame(1'b0, 1'b0, 7'h1E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
